// File: rtl/keycode_pkg.sv
// Shared constants, FSM state type and direction-key test for the keycode arbiter.
package keycode_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_D    = 8'h07;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_W    = 8'h1A;

    typedef enum logic [1:0] {
        IDLE,
        PURGE,
        ADD
    } arb_state_e;

    function automatic logic is_direction(input logic [7:0] code);
        return (code == KEY_A) || (code == KEY_D) || (code == KEY_S) || (code == KEY_W);
    endfunction

endpackage

// File: rtl/keycode_arbiter_if.sv
// HID report input, frame pulse and arbitrated direction outputs of the keycode arbiter.
interface keycode_arbiter_if;

    logic       report_valid;
    logic [7:0] keycode0;
    logic [7:0] keycode1;
    logic [7:0] keycode2;
    logic [7:0] keycode3;
    logic       frame_start;
    logic [7:0] keycode;
    logic       key_held;
    logic       dir_change;
    logic       busy;

    modport master (
        output report_valid, keycode0, keycode1, keycode2, keycode3, frame_start,
        input  keycode, key_held, dir_change, busy
    );

    modport slave (
        input  report_valid, keycode0, keycode1, keycode2, keycode3, frame_start,
        output keycode, key_held, dir_change, busy
    );

endinterface

// File: rtl/keycode_arbiter.sv
// Tracks held direction keys in press order and hands the most recent one to the
// ball stage once per frame; reports are folded in over a 4-cycle purge and 4-cycle add.
module keycode_arbiter
    import keycode_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    keycode_arbiter_if.slave bus
);

    typedef logic [STACK_DEPTH-1:0][7:0] stack_t;
    typedef logic [3:0][7:0]             report_t;

    arb_state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    stack_t     work_q, work_d;
    stack_t     stack_q, stack_d;
    logic [2:0] work_cnt_q, work_cnt_d;
    logic [2:0] wr_q, wr_d;
    logic [2:0] count_q, count_d;
    report_t    cap_q, cap_d;
    report_t    pend_q, pend_d;
    logic       pend_valid_q, pend_valid_d;
    logic [7:0] keycode_q, keycode_d;
    logic       dir_change_q, dir_change_d;
    logic       key_held_q, key_held_d;
    logic       busy_q, busy_d;

    report_t    report_in;
    logic [7:0] elem;
    logic [7:0] add_key;
    logic [7:0] top_key;
    logic       keep;
    logic       dup;
    logic       start;
    logic [2:0] wr_next;

    assign report_in = {bus.keycode3, bus.keycode2, bus.keycode1, bus.keycode0};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        work_d       = work_q;
        work_cnt_d   = work_cnt_q;
        wr_d         = wr_q;
        stack_d      = stack_q;
        count_d      = count_q;
        cap_d        = cap_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        keycode_d    = keycode_q;
        dir_change_d = 1'b0;
        elem         = KEY_NONE;
        add_key      = KEY_NONE;
        top_key      = KEY_NONE;
        keep         = 1'b0;
        dup          = 1'b0;
        start        = 1'b0;
        wr_next      = wr_q;

        // Reports arriving while a previous one is in flight park in the pending slot.
        if (state_q != IDLE && bus.report_valid) begin
            pend_d       = report_in;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.report_valid) begin
                    cap_d        = report_in;
                    pend_valid_d = 1'b0;
                    start        = 1'b1;
                end else if (pend_valid_q) begin
                    cap_d        = pend_q;
                    pend_valid_d = 1'b0;
                    start        = 1'b1;
                end
            end

            PURGE: begin
                for (int j = 0; j < STACK_DEPTH; j++) begin
                    if (2'(j) == idx_q) elem = work_q[j];
                end
                for (int s = 0; s < 4; s++) begin
                    if (cap_q[s] == elem) keep = 1'b1;
                end
                keep = keep && ({1'b0, idx_q} < work_cnt_q);
                // Survivors slide down to the write pointer, so order is preserved.
                for (int j = 0; j < STACK_DEPTH; j++) begin
                    if (keep && 3'(j) == wr_q) work_d[j] = elem;
                end
                wr_next = wr_q + {2'b00, keep};
                wr_d    = wr_next;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    work_cnt_d = wr_next;
                    state_d    = ADD;
                end
            end

            ADD: begin
                add_key = cap_q[idx_q];
                for (int j = 0; j < STACK_DEPTH; j++) begin
                    if (3'(j) < work_cnt_q && work_q[j] == add_key) dup = 1'b1;
                end
                if (is_direction(add_key) && !dup && work_cnt_q < 3'(STACK_DEPTH)) begin
                    for (int j = 0; j < STACK_DEPTH; j++) begin
                        if (3'(j) == work_cnt_q) work_d[j] = add_key;
                    end
                    work_cnt_d = work_cnt_q + 3'd1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    stack_d = work_d;
                    count_d = work_cnt_d;
                    state_d = IDLE;
                    if (pend_valid_q) begin
                        cap_d        = pend_q;
                        pend_valid_d = bus.report_valid;
                        start        = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // A new pass always starts from the freshest committed stack.
        if (start) begin
            work_d     = stack_d;
            work_cnt_d = count_d;
            wr_d       = 3'd0;
            idx_d      = 2'd0;
            state_d    = PURGE;
        end

        // The frame sample reads the registered stack, so a same-cycle commit is not seen.
        if (bus.frame_start) begin
            for (int j = 0; j < STACK_DEPTH; j++) begin
                if (3'(j) + 3'd1 == count_q) top_key = stack_q[j];
            end
            keycode_d    = top_key;
            dir_change_d = (top_key != keycode_q);
        end

        key_held_d = (count_d != 3'd0);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            work_q       <= '0;
            work_cnt_q   <= 3'd0;
            wr_q         <= 3'd0;
            stack_q      <= '0;
            count_q      <= 3'd0;
            cap_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            keycode_q    <= KEY_NONE;
            dir_change_q <= 1'b0;
            key_held_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            work_q       <= work_d;
            work_cnt_q   <= work_cnt_d;
            wr_q         <= wr_d;
            stack_q      <= stack_d;
            count_q      <= count_d;
            cap_q        <= cap_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            keycode_q    <= keycode_d;
            dir_change_q <= dir_change_d;
            key_held_q   <= key_held_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.keycode    = keycode_q;
    assign bus.dir_change = dir_change_q;
    assign bus.key_held   = key_held_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_keycode_arbiter.sv
// Bench for keycode_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (key list, report countdown, one-deep pending slot).
module tb_keycode_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    keycode_arbiter_if bus ();

    keycode_arbiter #(.STACK_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state: held keys oldest-first, cycles until the in-flight report lands.
    logic [7:0]      m_keys[$];
    int              m_left = 0;
    logic [3:0][7:0] m_report;
    logic [3:0][7:0] m_pend;
    bit              m_pend_valid = 0;
    logic [7:0]      m_key = 8'h00;
    logic            m_dir = 1'b0;
    logic            m_held = 1'b0;

    function automatic logic [3:0][7:0] mk(input logic [7:0] k0, input logic [7:0] k1,
                                           input logic [7:0] k2, input logic [7:0] k3);
        return {k3, k2, k1, k0};
    endfunction

    function automatic bit model_is_dir(input logic [7:0] k);
        return k == 8'h04 || k == 8'h07 || k == 8'h16 || k == 8'h1A;
    endfunction

    function automatic void model_apply(input logic [3:0][7:0] r);
        logic [7:0] kept[$];
        bit         found;
        foreach (m_keys[i]) begin
            found = 0;
            for (int s = 0; s < 4; s++) if (r[s] == m_keys[i]) found = 1;
            if (found) kept.push_back(m_keys[i]);
        end
        for (int s = 0; s < 4; s++) begin
            found = 0;
            foreach (kept[i]) if (kept[i] == r[s]) found = 1;
            if (model_is_dir(r[s]) && !found && kept.size() < 4) kept.push_back(r[s]);
        end
        m_keys = kept;
    endfunction

    function automatic void model_step(input logic rv, input logic [3:0][7:0] rep,
                                       input logic fs, input logic rs);
        logic [7:0] nk;
        if (rs) begin
            m_keys.delete();
            m_left = 0;
            m_pend_valid = 0;
            m_key = 8'h00;
            m_dir = 1'b0;
            m_held = 1'b0;
            return;
        end
        if (fs) begin
            nk = (m_keys.size() != 0) ? m_keys[$] : 8'h00;
            m_dir = (nk != m_key);
            m_key = nk;
        end else begin
            m_dir = 1'b0;
        end
        if (m_left != 0) begin
            m_left--;
            if (m_left == 0) begin
                model_apply(m_report);
                if (m_pend_valid) begin
                    m_report = m_pend;
                    m_pend_valid = 0;
                    m_left = 8;
                end
            end
            if (rv) begin
                m_pend = rep;
                m_pend_valid = 1;
            end
        end else if (rv) begin
            m_report = rep;
            m_pend_valid = 0;
            m_left = 8;
        end else if (m_pend_valid) begin
            m_report = m_pend;
            m_pend_valid = 0;
            m_left = 8;
        end
        m_held = (m_keys.size() != 0);
    endfunction

    // Drives one cycle of inputs, advances the model with them, and returns just after the edge.
    task automatic applyStimulus(input logic rv, input logic [3:0][7:0] rep,
                                 input logic fs, input logic rs);
        reset            = rs;
        bus.report_valid = rv;
        bus.keycode0     = rep[0];
        bus.keycode1     = rep[1];
        bus.keycode2     = rep[2];
        bus.keycode3     = rep[3];
        bus.frame_start  = fs;
        @(posedge clk);
        model_step(rv, rep, fs, rs);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        applyStimulus(1'b1, mk(8'h1A, 8'h00, 8'h00, 8'h00), 1'b1, 1'b1);
        checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL reset_keycode actual=%h expected=00", bus.keycode); end
        checks++; if (bus.key_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_held actual=%b expected=0", bus.key_held); end
        checks++; if (bus.dir_change !== 1'b0) begin errors++; $display("[TB] FAIL reset_dir_change actual=%b expected=0", bus.dir_change); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy actual=%b expected=0", bus.busy); end
        idleCycles(1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrides_report actual=%b expected=0", bus.busy); end
    endtask

    task automatic test_single_key;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, mk(8'h1A, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy actual=%b expected=1", bus.busy); end
        idleCycles(9);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h1A) begin errors++; $display("[TB] FAIL single_keycode actual=%h expected=1a", bus.keycode); end
        checks++; if (bus.dir_change !== 1'b1) begin errors++; $display("[TB] FAIL single_dir_change actual=%b expected=1", bus.dir_change); end
        checks++; if (bus.key_held !== 1'b1) begin errors++; $display("[TB] FAIL single_key_held actual=%b expected=1", bus.key_held); end
        idleCycles(1);
        checks++; if (bus.dir_change !== 1'b0) begin errors++; $display("[TB] FAIL single_dir_pulse_width actual=%b expected=0", bus.dir_change); end
    endtask

    task automatic test_priority;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, mk(8'h1A, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        idleCycles(9);
        applyStimulus(1'b1, mk(8'h1A, 8'h07, 8'h00, 8'h00), 1'b0, 1'b0);
        idleCycles(9);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h07) begin errors++; $display("[TB] FAIL priority_newest actual=%h expected=07", bus.keycode); end
        applyStimulus(1'b1, mk(8'h1A, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        idleCycles(9);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h1A) begin errors++; $display("[TB] FAIL priority_release actual=%h expected=1a", bus.keycode); end
        checks++; if (bus.dir_change !== 1'b1) begin errors++; $display("[TB] FAIL priority_dir_change actual=%b expected=1", bus.dir_change); end
    endtask

    task automatic test_filter_dup;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, mk(8'h05, 8'h04, 8'h04, 8'h00), 1'b0, 1'b0);
        idleCycles(9);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h04) begin errors++; $display("[TB] FAIL filter_keycode actual=%h expected=04", bus.keycode); end
        checks++; if (bus.key_held !== 1'b1) begin errors++; $display("[TB] FAIL filter_key_held actual=%b expected=1", bus.key_held); end
        applyStimulus(1'b1, mk(8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        idleCycles(9);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL empty_keycode actual=%h expected=00", bus.keycode); end
        checks++; if (bus.key_held !== 1'b0) begin errors++; $display("[TB] FAIL empty_key_held actual=%b expected=0", bus.key_held); end
        checks++; if (bus.dir_change !== 1'b1) begin errors++; $display("[TB] FAIL empty_dir_change actual=%b expected=1", bus.dir_change); end
    endtask

    task automatic test_back_to_back;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, mk(8'h04, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        applyStimulus(1'b1, mk(8'h07, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        applyStimulus(1'b1, mk(8'h16, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        idleCycles(20);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy actual=%b expected=0", bus.busy); end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h16) begin errors++; $display("[TB] FAIL b2b_keycode actual=%h expected=16", bus.keycode); end
        checks++; if (bus.key_held !== 1'b1) begin errors++; $display("[TB] FAIL b2b_key_held actual=%b expected=1", bus.key_held); end
    endtask

    task automatic test_commit_frame;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, mk(8'h07, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        idleCycles(6);
        checks++; if (bus.key_held !== 1'b0) begin errors++; $display("[TB] FAIL commit_early_held actual=%b expected=0", bus.key_held); end
        idleCycles(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL commit_frame_keycode actual=%h expected=00", bus.keycode); end
        checks++; if (bus.dir_change !== 1'b0) begin errors++; $display("[TB] FAIL commit_frame_dir_change actual=%b expected=0", bus.dir_change); end
        checks++; if (bus.key_held !== 1'b1) begin errors++; $display("[TB] FAIL commit_key_held actual=%b expected=1", bus.key_held); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL commit_busy actual=%b expected=0", bus.busy); end
        idleCycles(3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h07) begin errors++; $display("[TB] FAIL next_frame_keycode actual=%h expected=07", bus.keycode); end
    endtask

    task automatic test_reset_mid_add;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, mk(8'h04, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        idleCycles(5);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy actual=%b expected=0", bus.busy); end
        checks++; if (bus.key_held !== 1'b0) begin errors++; $display("[TB] FAIL midreset_key_held actual=%b expected=0", bus.key_held); end
        checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL midreset_keycode actual=%h expected=00", bus.keycode); end
        idleCycles(10);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.keycode !== 8'h00) begin errors++; $display("[TB] FAIL midreset_frame_keycode actual=%h expected=00", bus.keycode); end
        checks++; if (bus.key_held !== 1'b0) begin errors++; $display("[TB] FAIL midreset_frame_held actual=%b expected=0", bus.key_held); end
    endtask

    function automatic logic [7:0] pick_code();
        case ($urandom_range(0, 7))
            0:       return 8'h04;
            1:       return 8'h07;
            2:       return 8'h16;
            3:       return 8'h1A;
            4, 5:    return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic test_random;
        logic [3:0][7:0] rep;
        logic            rv, fs, rs;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int c = 0; c < 1500; c++) begin
            rv = ($urandom_range(0, 6) == 0);
            for (int s = 0; s < 4; s++) rep[s] = pick_code();
            fs = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 299) == 0);
            applyStimulus(rv, rep, fs, rs);
            checks++; if (bus.keycode !== m_key) begin errors++; $display("[TB] FAIL rand_keycode cycle=%0d actual=%h expected=%h", c, bus.keycode, m_key); end
            checks++; if (bus.dir_change !== m_dir) begin errors++; $display("[TB] FAIL rand_dir_change cycle=%0d actual=%b expected=%b", c, bus.dir_change, m_dir); end
            checks++; if (bus.key_held !== m_held) begin errors++; $display("[TB] FAIL rand_key_held cycle=%0d actual=%b expected=%b", c, bus.key_held, m_held); end
            checks++; if (bus.busy !== (m_left != 0)) begin errors++; $display("[TB] FAIL rand_busy cycle=%0d actual=%b expected=%b", c, bus.busy, m_left != 0); end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_priority();
        test_filter_dup();
        test_back_to_back();
        test_commit_frame();
        test_reset_mid_add();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
